// File: rtl/tanh_scheduler_pkg.sv
// Shared definitions for the tanh scheduler: Q5.26 constants, data width and FSM states.
package tanh_scheduler_pkg;

    localparam int DW = 32;

    // Q5.26 constants: +1.0, -1.0 and the saturation threshold 4.0
    localparam logic signed [31:0] ONE_Q     = 32'sh0400_0000;
    localparam logic signed [31:0] NEG_ONE_Q = 32'shFC00_0000;
    localparam logic signed [31:0] SAT_Q     = 32'sh1000_0000;

    // Variable selector encoding
    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_Y = 2'd1;
    localparam logic [1:0] SEL_Z = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/tanh_watchdog.sv
// Wait-cycle counter for core requests; tc flags that TIMEOUT cycles have elapsed.
module tanh_watchdog #(
    parameter int TIMEOUT = 64
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_V = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign tc = (count == TC_V);

    // Count enabled cycles, holding at the terminal value until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tanh_scheduler.sv
// Sequences tanh evaluation of x/y/z through a shared core, short-cutting
// saturated arguments and aborting a stalled core access via a watchdog.
module tanh_scheduler
    import tanh_scheduler_pkg::*;
#(
    parameter int DW      = tanh_scheduler_pkg::DW,
    parameter int TIMEOUT = 64
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] ddx,
    input  logic [DW-1:0] ddy,
    input  logic [DW-1:0] ddz,
    output logic          core_req,
    output logic [DW-1:0] core_arg,
    input  logic          core_ack,
    input  logic [DW-1:0] core_res,
    output logic [DW-1:0] tanx,
    output logic [DW-1:0] tany,
    output logic [DW-1:0] tanz,
    output logic          en,
    output logic          busy,
    output logic          err_timeout,
    output logic          err_overrun
);

    localparam logic signed [DW-1:0] ONE_V = DW'(ONE_Q);
    localparam logic signed [DW-1:0] NEG_V = DW'(NEG_ONE_Q);
    localparam logic signed [DW-1:0] SAT_V = DW'(SAT_Q);

    // |a| >= 4.0 without forming |a|, so the most negative code counts as saturated
    function automatic logic is_sat(input logic signed [DW-1:0] a);
        return (a >= SAT_V) || (a <= -SAT_V);
    endfunction

    function automatic logic signed [DW-1:0] sat_val(input logic signed [DW-1:0] a);
        return a[DW-1] ? NEG_V : ONE_V;
    endfunction

    state_t state, state_n;
    logic [1:0] sel;
    logic signed [DW-1:0] argx, argy, argz, arg_cur, res_val;
    logic ld_args, sel_clr, sel_inc, res_we, advance;
    logic req_set, req_clr, en_set, en_clr, ovr_set, to_set;
    logic wd_clr, wd_en, wd_tc;

    assign busy = (state != S_IDLE);

    tanh_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    // Select the argument currently being processed
    always_comb begin
        case (sel)
            SEL_X:   arg_cur = argx;
            SEL_Y:   arg_cur = argy;
            default: arg_cur = argz;
        endcase
    end

    // Next-state decode and per-cycle control strobes; abort overrides everything
    always_comb begin
        state_n = state;
        ld_args = 1'b0;
        sel_clr = 1'b0;
        sel_inc = 1'b0;
        res_we  = 1'b0;
        res_val = '0;
        advance = 1'b0;
        req_set = 1'b0;
        req_clr = 1'b0;
        en_set  = 1'b0;
        en_clr  = 1'b0;
        ovr_set = 1'b0;
        to_set  = 1'b0;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
            req_clr = 1'b1;
            en_clr  = 1'b1;
            sel_clr = 1'b1;
        end else begin
            if (start && (state != S_IDLE)) ovr_set = 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ld_args = 1'b1;
                        en_clr  = 1'b1;
                        sel_clr = 1'b1;
                        state_n = S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (is_sat(arg_cur)) begin
                        res_we  = 1'b1;
                        res_val = sat_val(arg_cur);
                        advance = 1'b1;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    req_set = 1'b1;
                    wd_clr  = 1'b1;
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    wd_en = 1'b1;
                    if (core_ack) begin
                        res_we  = 1'b1;
                        res_val = core_res;
                        req_clr = 1'b1;
                        advance = 1'b1;
                    end else if (wd_tc) begin
                        res_we  = 1'b1;
                        res_val = '0;
                        to_set  = 1'b1;
                        req_clr = 1'b1;
                        advance = 1'b1;
                    end
                end
                S_DONE: begin
                    en_set  = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
            if (advance) begin
                if (sel == SEL_Z) begin
                    state_n = S_DONE;
                end else begin
                    sel_inc = 1'b1;
                    state_n = S_LATCH;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Control registers: selector, core handshake, valid level and sticky errors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel         <= SEL_X;
            core_req    <= 1'b0;
            core_arg    <= '0;
            en          <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (sel_clr)      sel <= SEL_X;
            else if (sel_inc) sel <= sel + 2'd1;
            if (req_set) begin
                core_req <= 1'b1;
                core_arg <= arg_cur;
            end else if (req_clr) begin
                core_req <= 1'b0;
            end
            if (en_clr)      en <= 1'b0;
            else if (en_set) en <= 1'b1;
            if (to_set)  err_timeout <= 1'b1;
            if (ovr_set) err_overrun <= 1'b1;
        end
    end

    // Argument capture and result registers; results hold between writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            argx <= '0;
            argy <= '0;
            argz <= '0;
            tanx <= '0;
            tany <= '0;
            tanz <= '0;
        end else begin
            if (ld_args) begin
                argx <= ddx;
                argy <= ddy;
                argz <= ddz;
            end
            if (res_we) begin
                case (sel)
                    SEL_X:   tanx <= res_val;
                    SEL_Y:   tany <= res_val;
                    default: tanz <= res_val;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tanh_scheduler.sv
// Scoreboard bench for tanh_scheduler with a fixed-latency tanh core model.
module tb_tanh_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] ddx = '0, ddy = '0, ddz = '0;
    logic        core_req;
    logic [31:0] core_arg;
    logic        core_ack = 1'b0;
    logic [31:0] core_res = 32'hDEADBEEF;
    logic [31:0] tanx, tany, tanz;
    logic        en, busy, err_timeout, err_overrun;

    typedef struct {
        logic [31:0] x, y, z;
        logic        to, ovr;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] core_q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_idx = 0;
    logic        ack_on = 1'b1;
    logic        en_q = 1'b0;
    logic        req_seen = 1'b0;
    int          wait_cnt = 0;
    localparam int L = 2;

    tanh_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .ddx         (ddx),
        .ddy         (ddy),
        .ddz         (ddz),
        .core_req    (core_req),
        .core_arg    (core_arg),
        .core_ack    (core_ack),
        .core_res    (core_res),
        .tanx        (tanx),
        .tany        (tany),
        .tanz        (tanz),
        .en          (en),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tanh_lut(input logic [31:0] a);
        case (a)
            32'h0200_0000: return 32'h01D9_353F;
            32'hFE00_0000: return 32'hFE26_CAC1;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    // Core model: checks each request argument, acks L cycles after core_req rises
    always @(negedge clk) begin
        core_ack = 1'b0;
        core_res = 32'hDEADBEEF;
        if (!rst || !core_req) begin
            req_seen = 1'b0;
        end else if (!req_seen) begin
            req_seen = 1'b1;
            wait_cnt = L;
            if (core_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL core_req_unexpected actual_arg=%h required=none", core_arg);
            end else begin
                chk("core_arg", core_arg, core_q.pop_front());
            end
        end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0 && ack_on) begin
                core_ack = 1'b1;
                core_res = tanh_lut(core_arg);
            end
        end
    end

    // Monitor: on each rising en, pop the expected result set and compare
    always @(negedge clk) begin
        if (rst && en && !en_q) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL en_unexpected actual=1 required=0");
            end else begin
                e = sb_q.pop_front();
                chk("tanx", tanx, e.x);
                chk("tany", tany, e.y);
                chk("tanz", tanz, e.z);
                chk("err_timeout", {31'b0, err_timeout}, {31'b0, e.to});
                chk("err_overrun", {31'b0, err_overrun}, {31'b0, e.ovr});
                chk("latency", 32'(cyc - start_idx), 32'(e.lat));
            end
        end
        en_q = en;
    end

    task automatic do_start(input logic [31:0] x, y, z, input logic accepted);
        @(negedge clk);
        ddx = x;
        ddy = y;
        ddz = z;
        start = 1'b1;
        if (accepted) start_idx = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] x, y, z, input logic to, ovr, input int lat);
        exp_t t;
        t.x = x; t.y = y; t.z = z; t.to = to; t.ovr = ovr; t.lat = lat;
        sb_q.push_back(t);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL wait_en actual=timeout required=en_within_%0d", budget);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!core_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!core_req) begin
            total++;
            bad++;
            $display("FAIL wait_core_req actual=0 required=1");
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_core_req", {31'b0, core_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_en", {31'b0, en}, 32'd0);
        chk("rst_errs", {30'b0, err_timeout, err_overrun}, 32'd0);
        chk("rst_tanx", tanx, 32'd0);
        chk("rst_core_arg", core_arg, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Normal sequence through the core
        core_q.push_back(32'h0200_0000);
        core_q.push_back(32'h0000_0000);
        core_q.push_back(32'hFE00_0000);
        push_exp(32'h01D9_353F, 32'h0, 32'hFE26_CAC1, 1'b0, 1'b0, 16);
        do_start(32'h0200_0000, 32'h0000_0000, 32'hFE00_0000, 1'b1);
        wait_done(100);

        // Saturated x/y, start while en=1 must clear en
        core_q.push_back(32'h0200_0000);
        push_exp(32'h0400_0000, 32'hFC00_0000, 32'h01D9_353F, 1'b0, 1'b0, 8);
        do_start(32'h1400_0000, 32'hEC00_0000, 32'h0200_0000, 1'b1);
        chk("en_cleared_by_start", {31'b0, en}, 32'd0);
        wait_done(100);

        // start and abort together: start dropped, no overrun, en cleared
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", {31'b0, busy}, 32'd0);
        chk("abort_start_ovr", {31'b0, err_overrun}, 32'd0);
        chk("abort_start_en", {31'b0, en}, 32'd0);

        // Overrun: second start while busy is ignored; boundary codes 0x80000000 and 4.0
        core_q.push_back(32'hFE00_0000);
        push_exp(32'hFC00_0000, 32'hFE26_CAC1, 32'h0400_0000, 1'b0, 1'b1, 8);
        do_start(32'h8000_0000, 32'hFE00_0000, 32'h1000_0000, 1'b1);
        @(negedge clk);
        do_start(32'h0, 32'h0, 32'h0, 1'b0);
        wait_done(100);

        // Abort during WAIT for y: x (-4.0 -> -1.0) retained
        core_q.push_back(32'h0200_0000);
        do_start(32'hF000_0000, 32'h0200_0000, 32'h0, 1'b1);
        wait_req(20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_core_req", {31'b0, core_req}, 32'd0);
        chk("abort_en", {31'b0, en}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_tanx", tanx, 32'hFC00_0000);
        repeat (10) @(negedge clk);

        // Normal run after abort
        core_q.push_back(32'h0200_0000);
        core_q.push_back(32'h0000_0000);
        core_q.push_back(32'hFE00_0000);
        push_exp(32'h01D9_353F, 32'h0, 32'hFE26_CAC1, 1'b0, 1'b1, 16);
        do_start(32'h0200_0000, 32'h0000_0000, 32'hFE00_0000, 1'b1);
        wait_done(100);

        // Core never acks: watchdog writes zeros and flags timeout
        ack_on = 1'b0;
        repeat (3) core_q.push_back(32'h0200_0000);
        push_exp(32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 199);
        do_start(32'h0200_0000, 32'h0200_0000, 32'h0200_0000, 1'b1);
        wait_done(400);
        chk("timeout_core_req", {31'b0, core_req}, 32'd0);
        ack_on = 1'b1;

        // Asynchronous reset in the middle of WAIT
        core_q.push_back(32'h0200_0000);
        do_start(32'h1400_0000, 32'h0200_0000, 32'h0200_0000, 1'b1);
        wait_req(20);
        chk("pre_rst_tanx", tanx, 32'h0400_0000);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_core_req", {31'b0, core_req}, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_tanx", tanx, 32'd0);
        chk("async_rst_core_arg", core_arg, 32'd0);
        chk("async_rst_errs", {30'b0, err_timeout, err_overrun}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("core_q_empty", 32'(core_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tanh_scheduler.md
TANH_SCHEDULER -- requirements
Module: tanh_scheduler

Interface
REQ-001 Parameter DW, default 32: operand/result width, signed fixed point Q5.26 (1 sign, 5 integer, 26 fraction bits).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for core_ack before a watchdog abort.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request pulse from the integrator; ddx/ddy/ddz are valid in the same cycle.
REQ-006 abort  in  1  synchronous cancel, driven from the integrator's rest condition.
REQ-007 ddx, ddy, ddz  in  DW  state variables to be evaluated by tanh.
REQ-008 core_req  out  1  request to the shared tanh core.
REQ-009 core_arg  out  DW  argument presented to the core.
REQ-010 core_ack  in  1  one-cycle pulse; core_res is valid in the same cycle.
REQ-011 core_res  in  DW  tanh result in Q5.26.
REQ-012 tanx, tany, tanz  out  DW  result registers.
REQ-013 en  out  1  results valid (level).
REQ-014 busy  out  1  high in every state other than IDLE.
REQ-015 err_timeout, err_overrun  out  1 each  sticky error flags.

Function
REQ-016 The FSM SHALL have the states IDLE, LATCH, ISSUE, WAIT and DONE, with a 2-bit index sel selecting x=0, y=1, z=2.
REQ-017 In IDLE, start=1 SHALL capture ddx/ddy/ddz into argument registers, clear en, set sel=0 and move to LATCH; en SHALL be 0 from the next cycle.
REQ-018 In LATCH, if |arg[sel]| >= 4.0 (0x10000000), the block SHALL write +1.0 (0x04000000) or -1.0 (0xFC000000) by sign into the result register, without a core access, then go to NEXT-handling; otherwise it SHALL go to ISSUE.
REQ-019 NEXT-handling: if sel<2, increment sel and return to LATCH; if sel=2, go to DONE.
REQ-020 In ISSUE, the block SHALL set core_req=1 and core_arg=arg[sel], go to WAIT and clear the watchdog counter.
REQ-021 In WAIT, core_req and core_arg SHALL be held stable until core_ack is sampled.
REQ-022 On core_ack in WAIT, the block SHALL store core_res into the result register for sel, drop core_req on the next edge, and perform NEXT-handling.
REQ-023 core_ack SHALL be ignored outside WAIT.
REQ-024 If the watchdog reaches TIMEOUT-1 in WAIT without core_ack, the block SHALL write 0 into the result, set err_timeout, drop core_req and perform NEXT-handling.
REQ-025 In DONE, the block SHALL set en=1 and return to IDLE.
REQ-026 en SHALL stay 1 until the next accepted start or an abort.
REQ-027 Results SHALL be held between updates.
REQ-028 A start seen while busy=1 SHALL be ignored and SHALL set err_overrun.
REQ-029 abort=1 in any state SHALL take precedence over all other events: on the next edge the FSM goes to IDLE and core_req=0, en=0, sel=0; results and error flags are held.
REQ-030 If start and abort occur in the same cycle, abort SHALL win and start SHALL be dropped without setting a flag.
REQ-031 Latency from start to en: with no saturation it SHALL be 3*(3+L)+1 cycles, where L is the core ack latency in cycles after core_req rises; each saturated variable SHALL cost 1 cycle instead of 3+L.
REQ-032 The |arg| comparison SHALL treat 0x80000000 as saturated negative, giving -1.0.

Reset
REQ-033 While rst=0, the FSM SHALL be in IDLE; sel, core_req, en, busy, err_timeout and err_overrun SHALL be 0; core_arg, tanx, tany, tanz and the argument registers SHALL be 0.
REQ-034 Reset SHALL act asynchronously and release synchronously on the first clk edge with rst=1.
REQ-035 Error flags SHALL be cleared only by reset.

Structure
REQ-036 The shared package SHALL hold the Q5.26 constants ONE_Q=0x04000000, NEG_ONE_Q=0xFC000000 and SAT_Q=0x10000000, the FSM state enum, and DW.
REQ-037 The watchdog counter (clear, enable, terminal-count output, TIMEOUT parameter) SHALL be one sub-module, tanh_watchdog.
REQ-038 All other logic SHALL stay inside tanh_scheduler.

Verification
REQ-039 Core model with L=2; ddx=0x02000000 (0.5), ddy=0, ddz=0xFE000000 (-0.5) -> three core_req transactions in order x,y,z; tanx=0x01D9353F, tany=0, tanz=0xFE26CAC1; en rises at cycle 16; err flags=0.
REQ-040 ddx=0x14000000 (5.0), ddy=0xEC000000 (-5.0), ddz=0x02000000 -> only one core transaction (z); tanx=0x04000000, tany=0xFC000000; en at 3*... = 1+1+(3+2)+1 = 8 cycles.
REQ-041 Core never acks, TIMEOUT=64, all args 0.5 -> err_timeout=1, all results 0, en after about 3*66 cycles, core_req low afterwards.
REQ-042 abort pulsed during WAIT for y -> core_req=0 and en=0 next cycle, tanx retained; a subsequent start completes normally.
REQ-043 start re-pulsed while busy -> err_overrun=1, the running sequence is undisturbed; start with en=1 -> en=0 on the next cycle.
REQ-044 rst asserted mid-WAIT -> all outputs 0 immediately, without a clk edge.
